pc_gen_ras: RTL and testbench

PC_GEN_RAS -- requirements
Module: pc_gen_ras

---
 rtl/pc_gen_ras.sv | 124 ++++++++++++
 tb/tb_pc_gen_ras.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch-stage PC generator with an optional circular return-address stack.
// Define NPC_RAS_EN to compile in the return-address stack; without it the RAS outputs are tied off.
module pc_gen_ras #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_op,
  input  logic [31:0] pc_d,
  input  logic [25:0] imm,
  input  logic [31:0] ra,
  input  logic        call,
  input  logic        ret,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] ras_top,
  output logic        ras_empty,
  output logic        ras_miss
);

  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign br_off     = {{14{imm[15]}}, imm[15:0], 2'b00};
  assign br_target  = pc_d + 32'd4 + br_off;
  assign jmp_target = {pc_d[31:28], imm, 2'b00};

  // Exception entry beats eret, which beats the normal next-PC select.
  always_comb begin
    npc = pc + 32'd4;
    if (req) begin
      npc = EXC_VEC;
    end else if (eret) begin
      npc = epc;
    end else begin
      case (npc_op)
        2'b00:   npc = pc + 32'd4;
        2'b01:   npc = br_target;
        2'b10:   npc = jmp_target;
        default: npc = ra;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (pc_en || req) begin
      pc <= npc;
    end
  end

`ifdef NPC_RAS_EN
  localparam int         PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [31:0]   stack [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_m1;
  logic [PW:0]   cnt;
  logic [31:0]   link;
  logic          upd_ok;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;

  // Return lands after the delay slot.
  assign link   = pc_d + 32'd8;
  assign ptr_m1 = ptr - PW'(1);

  assign ras_empty = (cnt == '0);
  assign ras_top   = ras_empty ? 32'd0 : stack[ptr_m1];
  assign ras_miss  = ret && (ras_empty || (ras_top != ra));

  assign upd_ok  = pc_en && !req;
  assign do_repl = upd_ok && call && ret && !ras_empty;
  assign do_push = upd_ok && call && !do_repl;
  assign do_pop  = upd_ok && ret && !call && !ras_empty;

  // Entries are not reset; cnt alone decides validity.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (do_repl) begin
        stack[ptr_m1] <= link;
      end else if (do_push) begin
        stack[ptr] <= link;
      end
    end
  end

  // When full, a push wraps over the oldest slot and cnt stays saturated.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (req) begin
      cnt <= '0;
    end else if (do_push) begin
      ptr <= ptr + PW'(1);
      if (cnt != FULL) begin
        cnt <= cnt + 1'b1;
      end
    end else if (do_pop) begin
      ptr <= ptr_m1;
      cnt <= cnt - 1'b1;
    end
  end
`else
  logic unused_ras;

  assign unused_ras = ^{call, ret};
  assign ras_top    = 32'd0;
  assign ras_empty  = 1'b1;
  assign ras_miss   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: scoreboard-driven bench for pc_gen_ras; RAS scenarios follow NPC_RAS_EN.
module tb_pc_gen_ras;
  logic        clk = 1'b0;
  logic        reset, pc_en, req, eret, call, ret;
  logic [31:0] epc, pc_d, ra;
  logic [1:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] pc, npc, ras_top;
  logic        ras_empty, ras_miss;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [31:0] model[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  pc_gen_ras dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .req(req), .eret(eret), .epc(epc),
    .npc_op(npc_op), .pc_d(pc_d), .imm(imm), .ra(ra), .call(call), .ret(ret),
    .pc(pc), .npc(npc), .ras_top(ras_top), .ras_empty(ras_empty), .ras_miss(ras_miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_en = 1'b1; req = 1'b1; eret = 1'b1; call = 1'b1; ret = 1'b1;
    epc = 32'h1234_0000; npc_op = 2'b11; pc_d = 32'h3000; imm = '0; ra = 32'h5555_0000;
    sb.push_back(32'h0000_3000);
    tick();
    tick();
    exp = sb.pop_front();
    checks++; if (pc !== exp) begin failures++; $display("FAIL reset_pc got=%h want=%h", pc, exp); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", ras_empty); end
    checks++; if (ras_top !== 32'd0) begin failures++; $display("FAIL reset_top got=%h want=0", ras_top); end
`ifdef NPC_RAS_EN
    sb.push_back(32'd1);
`else
    sb.push_back(32'd0);
`endif
    #1;
    exp = sb.pop_front();
    checks++; if (ras_miss !== exp[0]) begin failures++; $display("FAIL reset_miss got=%b want=%b", ras_miss, exp[0]); end
    reset = 1'b1; req = 1'b0; eret = 1'b0; call = 1'b0; ret = 1'b0; npc_op = 2'b00;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) sb.push_back(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      exp = sb.pop_front();
      checks++; if (pc !== exp) begin failures++; $display("FAIL seq_pc[%0d] got=%h want=%h", i, pc, exp); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_branch_jump();
    pc_en = 1'b0;
    pc_d = 32'h3010; npc_op = 2'b01; imm = 26'h000FFFF; sb.push_back(32'h3010);
    #1; exp = sb.pop_front();
    checks++; if (npc !== exp) begin failures++; $display("FAIL branch_back got=%h want=%h", npc, exp); end
    npc_op = 2'b10; imm = 26'h0000C10; sb.push_back(32'h0000_3040);
    #1; exp = sb.pop_front();
    checks++; if (npc !== exp) begin failures++; $display("FAIL jump got=%h want=%h", npc, exp); end
    pc_d = 32'hA000_0000; imm = 26'h3FF_FFFF; sb.push_back(32'hAFFF_FFFC);
    #1; exp = sb.pop_front();
    checks++; if (npc !== exp) begin failures++; $display("FAIL jump_region got=%h want=%h", npc, exp); end
    pc_d = 32'hFFFF_FFF8; npc_op = 2'b01; imm = 26'h0000001; sb.push_back(32'h0000_0000);
    #1; exp = sb.pop_front();
    checks++; if (npc !== exp) begin failures++; $display("FAIL branch_wrap got=%h want=%h", npc, exp); end
    npc_op = 2'b11; ra = 32'h1234_5678; sb.push_back(32'h1234_5678);
    #1; exp = sb.pop_front();
    checks++; if (npc !== exp) begin failures++; $display("FAIL reg_jump got=%h want=%h", npc, exp); end
    sb.push_back(32'h300C);
    tick(); exp = sb.pop_front();
    checks++; if (pc !== exp) begin failures++; $display("FAIL stall_hold got=%h want=%h", pc, exp); end
    npc_op = 2'b00;
  endtask

  task automatic test_exception();
    pc_en = 1'b0; req = 1'b1; eret = 1'b1; epc = 32'h3020; sb.push_back(32'h0000_4180);
    #1; exp = sb.pop_front();
    checks++; if (npc !== exp) begin failures++; $display("FAIL exc_npc got=%h want=%h", npc, exp); end
    sb.push_back(32'h0000_4180);
    tick(); exp = sb.pop_front();
    checks++; if (pc !== exp) begin failures++; $display("FAIL exc_pc got=%h want=%h", pc, exp); end
    req = 1'b0; pc_en = 1'b1; npc_op = 2'b01; sb.push_back(32'h3020);
    tick(); exp = sb.pop_front();
    checks++; if (pc !== exp) begin failures++; $display("FAIL eret_pc got=%h want=%h", pc, exp); end
    eret = 1'b0; npc_op = 2'b00;
  endtask

`ifdef NPC_RAS_EN
  task automatic test_ras_overflow();
    model.delete();
    pc_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_d = 32'h3000 + 32'(16 * i); call = 1'b1;
      model.push_back(pc_d + 32'd8);
      if (model.size() > 4) void'(model.pop_front());
      tick();
    end
    call = 1'b0;
    while (model.size() > 0) sb.push_back(model.pop_back());
    for (int i = 0; i < 4; i++) begin
      exp = sb.pop_front();
      ret = 1'b1; ra = exp; #1;
      checks++; if (ras_top !== exp) begin failures++; $display("FAIL ovf_top[%0d] got=%h want=%h", i, ras_top, exp); end
      checks++; if (ras_miss !== 1'b0) begin failures++; $display("FAIL ovf_miss[%0d] got=%b want=0", i, ras_miss); end
      tick();
    end
    ret = 1'b0;
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b want=1", ras_empty); end
  endtask

  task automatic test_ras_edges();
    ret = 1'b1; ra = 32'h3100; #1;
    checks++; if (ras_miss !== 1'b1) begin failures++; $display("FAIL empty_miss got=%b want=1", ras_miss); end
    tick();
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL empty_pop got=%b want=1", ras_empty); end
    ret = 1'b0; call = 1'b1; pc_d = 32'h3200; pc_en = 1'b0;
    tick();
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL stall_block got=%b want=1", ras_empty); end
    pc_en = 1'b1; sb.push_back(32'h3208);
    tick(); exp = sb.pop_front();
    checks++; if (ras_top !== exp) begin failures++; $display("FAIL one_push got=%h want=%h", ras_top, exp); end
    ret = 1'b1; pc_d = 32'h3300; sb.push_back(32'h3308);
    tick(); exp = sb.pop_front();
    checks++; if (ras_top !== exp) begin failures++; $display("FAIL call_ret_top got=%h want=%h", ras_top, exp); end
    call = 1'b0; ra = 32'h3308; #1;
    checks++; if (ras_miss !== 1'b0) begin failures++; $display("FAIL call_ret_miss got=%b want=0", ras_miss); end
    tick();
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL call_ret_count got=%b want=1", ras_empty); end
    ret = 1'b0;
  endtask

  task automatic test_req_clear();
    call = 1'b1;
    for (int i = 0; i < 3; i++) begin pc_d = 32'h3400 + 32'(4 * i); tick(); end
    checks++; if (ras_empty !== 1'b0) begin failures++; $display("FAIL pre_req_empty got=%b want=0", ras_empty); end
    req = 1'b1; sb.push_back(32'h0000_4180);
    tick(); exp = sb.pop_front();
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL req_clear got=%b want=1", ras_empty); end
    checks++; if (pc !== exp) begin failures++; $display("FAIL req_pc got=%h want=%h", pc, exp); end
    req = 1'b0; call = 1'b0;
  endtask
`else
  task automatic test_ras_disabled();
    pc_en = 1'b1; call = 1'b1; pc_d = 32'h3500;
    tick(); tick();
    call = 1'b0; ret = 1'b1; ra = 32'h3508; #1;
    checks++; if (ras_miss !== 1'b0) begin failures++; $display("FAIL dis_miss got=%b want=0", ras_miss); end
    checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL dis_empty got=%b want=1", ras_empty); end
    checks++; if (ras_top !== 32'd0) begin failures++; $display("FAIL dis_top got=%h want=0", ras_top); end
    ret = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_stall();
    pc_en = 1'b1; npc_op = 2'b11; ra = 32'h7770; tick();
    pc_en = 1'b0; tick();
    reset = 1'b0; sb.push_back(32'h0000_3000);
    tick(); exp = sb.pop_front();
    checks++; if (pc !== exp) begin failures++; $display("FAIL stall_reset got=%h want=%h", pc, exp); end
    reset = 1'b1; npc_op = 2'b00;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_exception();
`ifdef NPC_RAS_EN
    test_ras_overflow();
    test_ras_edges();
    test_req_clear();
`else
    test_ras_disabled();
`endif
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
